wave_table_writer: RTL and testbench
====================================

# wave_table_writer

- Fills a waveform lookup RAM with one full period of a selected waveform, one entry per write, under a start/busy/done handshake.
- It is the write-side counterpart to the DDS wave readers:
  - The readers step a phase address into a 128-entry table every clock.
  - This block produces that table contents at run time, so one RAM can be reloaded with triangle, sawtooth, square or clear patterns instead of fixed ROMs.
- Sits between the control logic and the write port of the wave table RAM.

## Interface

Parameters:
- ADDR_W, default 7: table address width; depth = 2^ADDR_W. Must satisfy ADDR_W ≤ DATA_W.
- DATA_W, default 16: sample width, unsigned offset-binary.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a table fill; sampled in IDLE only.
- wave_sel  input  2  0 triangle, 1 sawtooth, 2 square, 3 clear (all zero).
- atten  input  4  right-shift applied to every sample (0 = full scale).
- wr_ready  input  1  RAM side accepts the current write this cycle.
- wr_en  output  1  write request valid.
- wr_addr  output  ADDR_W  table address being written.
- wr_data  output  DATA_W  sample being written.
- busy  output  1  high while in WRITE.
- done  output  1  one-cycle pulse after the last entry is accepted.

## Operation

- FSM states: IDLE, WRITE, DONE. Reset → IDLE.
- IDLE:
  - start=1 latches wave_sel and atten into internal registers and clears the address counter to 0.
  - Next state is WRITE.
  - Later changes to wave_sel or atten have no effect until the next start.
- WRITE:
  - wr_en=1, with wr_addr = counter and wr_data = f(counter) >> atten_latched.
  - A write is accepted on any cycle with wr_en=1 and wr_ready=1.
  - On acceptance the counter increments and wr_addr/wr_data update to the next entry in the same edge.
  - With wr_ready=0, wr_addr and wr_data hold stable; no entry is skipped or repeated.
  - Acceptance of address 2^ADDR_W−1 → DONE, and wr_en drops to 0.
- DONE: done=1 for exactly one cycle, then → IDLE.
- start is ignored in WRITE and DONE; no queuing.
- Sample function for address a, with D = 2^ADDR_W:
  - Triangle: (a < D/2 ? a : D−1−a) << (DATA_W−ADDR_W+1). The table is symmetric; the peak appears at a = D/2−1 and a = D/2.
  - Sawtooth: a << (DATA_W−ADDR_W).
  - Square: a < D/2 ? all-ones : 0.
  - Clear: 0.
- Attenuation is a logical right shift with zero fill. atten ≥ DATA_W yields 0.
- All outputs are registered.

## Timing

- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. The latched config and the counter are also 0.
- Reset deassertion is taken synchronously to clk; the first start can be sampled on the first edge after release.
- Latency: start sampled at edge N → wr_en=1, wr_addr=0 valid after edge N.
- With wr_ready held high:
  - Address k is on the bus between edges N+k and N+k+1.
  - The last entry is accepted at edge N+D.
  - done is high between edges N+D and N+D+1.
  - busy is high for exactly D cycles.
- Each wr_ready=0 cycle in WRITE extends the fill by exactly one cycle.
- Reset asserted mid-fill:
  - Outputs clear immediately (asynchronously).
  - The partially written table is left as-is; no done pulse.
- start=1 on the same cycle done=1: ignored. A new fill needs start sampled in IDLE.

## Test plan

- Triangle fill, defaults, atten=0, wr_ready=1 → 128 writes in 128 consecutive cycles:
  - addr 0 = 0x0000, addr 1 = 0x0400, addr 63 = 0xFC00, addr 64 = 0xFC00, addr 127 = 0x0000.
  - done pulses once at cycle 129 after start.
- Sawtooth, atten=2 → addr 0 = 0x0000, addr 1 = 0x0080, addr 127 = 0x3F80.
- Square, wr_ready toggling 1/0 every cycle:
  - Each address is held while ready is low; addr 0–63 = 0xFFFF, addr 64–127 = 0x0000.
  - Total busy = 255 cycles; no address is missing or duplicated.
- Clear, with start re-pulsed and wave_sel changed to 0 during WRITE → all 128 entries are 0x0000; the second start is ignored; exactly one done.
- Reset low at addr 40 of a triangle fill:
  - wr_en, busy and done go to 0 without waiting for a clock edge; wr_addr = 0.
  - After release, a new start writes from addr 0.
- atten=15 triangle → every write is 0x0001 or 0x0000 (0x0001 only at addr 32–95); atten applied after the shift.

Source files
------------

// File: rtl/wave_table_writer_if.sv
// Write port bundle between the wave table writer and the wave table RAM.
// The writer drives address, data and request; the RAM side answers with ready.
interface wave_table_writer_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/wave_table_writer.sv
// Fills one period of a triangle, sawtooth, square or clear pattern into a wave table RAM,
// one entry per accepted write, under a start/busy/done handshake.
module wave_table_writer #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 wave_sel,
  input  logic [3:0]                 atten,
  wave_table_writer_if.master        wr,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        atten_q, atten_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              last;

  // Upper half of the triangle folds back via ~a, which equals D-1-a in ADDR_W bits.
  function automatic logic [DATA_W-1:0] sample(input logic [ADDR_W-1:0] a,
                                               input logic [1:0]        sel,
                                               input logic [3:0]        sh);
    logic [DATA_W-1:0] raw;
    logic [ADDR_W-1:0] fold;
    fold = a[ADDR_W-1] ? ~a : a;
    unique case (sel)
      2'd0:    raw = DATA_W'(fold) << (DATA_W - ADDR_W + 1);
      2'd1:    raw = DATA_W'(a) << (DATA_W - ADDR_W);
      2'd2:    raw = a[ADDR_W-1] ? '0 : '1;
      default: raw = '0;
    endcase
    return raw >> sh;
  endfunction

  assign addr_inc = addr_q + ADDR_W'(1);
  assign accept   = wr_en_q && wr.wr_ready;
  assign last     = (addr_q == LastAddr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWrite;
      StWrite: if (accept && last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs; acceptance advances to the next entry on the same edge.
  always_comb begin
    sel_d   = sel_q;
    atten_d = atten_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sel_d   = wave_sel;
          atten_d = atten;
          addr_d  = '0;
          data_d  = sample('0, wave_sel, atten);
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StWrite: begin
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
        if (accept) begin
          if (last) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
            data_d  = '0;
          end else begin
            addr_d = addr_inc;
            data_d = sample(addr_inc, sel_q, atten_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q   <= '0;
      atten_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      atten_q <= atten_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_wave_table_writer.sv
// Directed bench for wave_table_writer: fills each waveform and checks hand-computed entries,
// handshake timing, stall behaviour, ignored restarts and asynchronous reset mid-fill.
module tb_wave_table_writer;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned D  = 128;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] wave_sel;
  logic [3:0] atten;
  logic       busy;
  logic       done;

  wave_table_writer_if #(.ADDR_W(AW), .DATA_W(DW)) wr_bus ();

  wave_table_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .wave_sel (wave_sel),
    .atten    (atten),
    .wr       (wr_bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [DW-1:0] tbl [D];
  int            writes, order_err, hold_err, done_cnt, done_at, busy_cyc, post_busy;
  logic          first_en;
  logic [AW-1:0] first_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Starts a fill and logs every accepted write into tbl; disturb re-pulses start mid-fill
  // (with wave_sel changed) and again on the done cycle.
  task automatic do_fill(input logic [1:0] sel, input logic [3:0] att, input bit toggle,
                         input bit disturb);
    int            exp_addr;
    logic [DW-1:0] prev_data;
    bit            prev_hold;
    for (int i = 0; i < D; i++) tbl[i] = 16'hDEAD;
    writes = 0; order_err = 0; hold_err = 0; done_cnt = 0; done_at = -1;
    busy_cyc = 0; post_busy = 0; exp_addr = 0; prev_hold = 0; prev_data = '0;
    wave_sel = sel; atten = att; start = 1'b1; wr_bus.wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      wr_bus.wr_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (k == 0) begin
        first_en   = wr_bus.wr_en;
        first_addr = wr_bus.wr_addr;
      end
      if (busy) begin
        if (done_cnt == 0) busy_cyc++;
        else post_busy++;
      end
      if (wr_bus.wr_en) begin
        if (int'(wr_bus.wr_addr) != exp_addr) order_err++;
        if (prev_hold && wr_bus.wr_data !== prev_data) hold_err++;
        if (wr_bus.wr_ready) begin
          if (done_cnt == 0) tbl[wr_bus.wr_addr] = wr_bus.wr_data;
          writes++;
          exp_addr++;
        end
        prev_hold = !wr_bus.wr_ready;
        prev_data = wr_bus.wr_data;
      end
      start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = k;
        if (disturb) start = 1'b1;
      end
      if (disturb && k == 5) begin
        start    = 1'b1;
        wave_sel = 2'd0;
      end
      if (done_cnt > 0 && k >= done_at + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int bad;
    reset = 1'b0; start = 1'b0; wave_sel = 2'd0; atten = 4'd0; wr_bus.wr_ready = 1'b0;
    #12;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_bus.wr_en), 32'h0);
    check("rst_wr_addr", 32'(wr_bus.wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_bus.wr_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Triangle, full scale, ready always high.
    do_fill(2'd0, 4'd0, 1'b0, 1'b0);
    check("tri_first_en", 32'(first_en), 32'h1);
    check("tri_first_addr", 32'(first_addr), 32'h0);
    check("tri_writes", 32'(writes), 32'd128);
    check("tri_order", 32'(order_err), 32'h0);
    check("tri_busy", 32'(busy_cyc), 32'd128);
    check("tri_done_cnt", 32'(done_cnt), 32'h1);
    check("tri_done_at", 32'(done_at), 32'd128);
    check("tri_a0", 32'(tbl[0]), 32'h0000);
    check("tri_a1", 32'(tbl[1]), 32'h0400);
    check("tri_a63", 32'(tbl[63]), 32'hFC00);
    check("tri_a64", 32'(tbl[64]), 32'hFC00);
    check("tri_a127", 32'(tbl[127]), 32'h0000);

    // Sawtooth, atten 2.
    do_fill(2'd1, 4'd2, 1'b0, 1'b0);
    check("saw_writes", 32'(writes), 32'd128);
    check("saw_a0", 32'(tbl[0]), 32'h0000);
    check("saw_a1", 32'(tbl[1]), 32'h0080);
    check("saw_a127", 32'(tbl[127]), 32'h3F80);

    // Square with ready toggling every cycle.
    do_fill(2'd2, 4'd0, 1'b1, 1'b0);
    bad = 0;
    for (int a = 0; a < D; a++) if (tbl[a] !== ((a < 64) ? 16'hFFFF : 16'h0000)) bad++;
    check("sq_values", 32'(bad), 32'h0);
    check("sq_writes", 32'(writes), 32'd128);
    check("sq_order", 32'(order_err), 32'h0);
    check("sq_hold", 32'(hold_err), 32'h0);
    check("sq_busy", 32'(busy_cyc), 32'd255);
    check("sq_done_cnt", 32'(done_cnt), 32'h1);

    // Clear, with start re-pulsed and wave_sel changed mid-fill and on the done cycle.
    do_fill(2'd3, 4'd0, 1'b0, 1'b1);
    bad = 0;
    for (int a = 0; a < D; a++) if (tbl[a] !== 16'h0000) bad++;
    check("clr_values", 32'(bad), 32'h0);
    check("clr_writes", 32'(writes), 32'd128);
    check("clr_order", 32'(order_err), 32'h0);
    check("clr_done_cnt", 32'(done_cnt), 32'h1);
    check("clr_post_busy", 32'(post_busy), 32'h0);

    // Asynchronous reset at address 40 of a triangle fill.
    wave_sel = 2'd0; atten = 4'd0; wr_bus.wr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && wr_bus.wr_addr != 7'd40; k++) @(negedge clk);
    check("rst_mid_addr", 32'(wr_bus.wr_addr), 32'd40);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_wr_en", 32'(wr_bus.wr_en), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", 32'(done), 32'h0);
    check("rst_mid_wr_addr", 32'(wr_bus.wr_addr), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_fill(2'd0, 4'd0, 1'b0, 1'b0);
    check("refill_first_addr", 32'(first_addr), 32'h0);
    check("refill_writes", 32'(writes), 32'd128);
    check("refill_order", 32'(order_err), 32'h0);
    check("refill_a1", 32'(tbl[1]), 32'h0400);

    // Triangle at atten 15: only the top bit survives, set for addresses 32..95.
    do_fill(2'd0, 4'd15, 1'b0, 1'b0);
    bad = 0;
    for (int a = 0; a < D; a++) if (tbl[a] !== ((a >= 32 && a <= 95) ? 16'h0001 : 16'h0000)) bad++;
    check("att15_values", 32'(bad), 32'h0);
    check("att15_a31", 32'(tbl[31]), 32'h0000);
    check("att15_a32", 32'(tbl[32]), 32'h0001);
    check("att15_a95", 32'(tbl[95]), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
